pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory and execute-control bus between the PC sequencer
// and the fetch/decode side of the core.
interface pc_sequencer_if #(
  parameter int Psize = 4
);
  logic [Psize-1:0] pc;
  logic [Psize-1:0] br_target;
  logic             imem_req;
  logic             imem_ack;
  logic             instr_valid;
  logic             br_en;
  logic             br_cond;
  logic             call;
  logic             ret;

  modport master (
    output pc, imem_req, instr_valid,
    input  imem_ack, br_en, br_cond,
    input  call, ret, br_target
  );

  modport slave (
    input  pc, imem_req, instr_valid,
    output imem_ack, br_en, br_cond,
    output call, ret, br_target
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch/execute FSM with branch, call/return
// stack and a sticky stack-error flag.
module pc_sequencer #(
  parameter int Psize  = 4,
  parameter int Sdepth = 4
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           run,
  input  logic           halt_req,
  output logic           busy,
  output logic           stack_err,
  pc_sequencer_if.master bus
);

  localparam int SW = $clog2(Sdepth + 1);
  localparam int IW = (Sdepth > 1) ? $clog2(Sdepth) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] pc_nxt;
  logic [Psize-1:0] stk [Sdepth];
  logic [SW-1:0]    sp;
  logic [SW-1:0]    sp_nxt;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             full;
  logic             empty;
  logic             push;
  logic             err_set;
  logic             take_ret;
  logic             take_br;
  logic             take_call;

  assign pc_inc = pc + Psize'(1);
  assign full   = (sp == SW'(Sdepth));
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SW'(1));

  // Priority resolved up front so the decoder sees one-hot selects
  assign take_ret  = bus.ret;
  assign take_br   = ~bus.ret & bus.br_en & bus.br_cond;
  assign take_call = ~bus.ret & ~(bus.br_en & bus.br_cond) & bus.call;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    push      = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = halt_req ? HALT : FETCH;
        pc_nxt    = pc_inc;
        unique case (1'b1)
          take_ret: begin
            if (empty) begin
              err_set = 1'b1;
            end else begin
              pc_nxt = stk[rd_idx];
              sp_nxt = sp - SW'(1);
            end
          end
          take_br: begin
            pc_nxt = bus.br_target;
          end
          take_call: begin
            if (full) begin
              err_set = 1'b1;
            end else begin
              push   = 1'b1;
              pc_nxt = bus.br_target;
              sp_nxt = sp + SW'(1);
            end
          end
          default: ;
        endcase
      end
      HALT: begin
        if (!run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      pc        <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      sp    <= sp_nxt;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Entries above sp are dead, so storage needs no reset
  always_ff @(posedge clk) begin
    if (push) stk[wr_idx] <= pc_inc;
  end

  assign bus.pc          = pc;
  assign bus.imem_req    = (state == FETCH);
  assign bus.instr_valid = (state == EXEC);
  assign busy            = (state == FETCH) || (state == EXEC);

endmodule
